// File: rtl/binpack_pkg.sv
// Shared types and defaults for the block-1 binary output packer.
package binpack_pkg;

  localparam int CH         = 8;
  localparam int WORD_W_DEF = 32;
  localparam int N_BITS_DEF = 900;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FINAL,
    DONE
  } state_e;

  function automatic int n_words(input int n_bits, input int word_w);
    return (n_bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/binpack_lane.sv
// One channel of the packer: MSB-first shift register, left-aligned word register
// and, with BINPACK_POPCNT_EN, a count of accepted 1-bits.
module binpack_lane #(
  parameter int WORD_W = 32,
`ifdef BINPACK_POPCNT_EN
  parameter int BW     = 5,
  parameter int CW     = 10
`else
  parameter int BW     = 5
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic              bit_i,
  input  logic              load_i,
  input  logic [BW-1:0]     pad_i,
`ifdef BINPACK_POPCNT_EN
  output logic [WORD_W-1:0] word_o,
  output logic [CW-1:0]     popcnt_o
`else
  output logic [WORD_W-1:0] word_o
`endif
);

  logic [WORD_W-1:0] sr_q;
  logic [WORD_W-1:0] sr_d;
  logic [WORD_W-1:0] word_q;

  // Word captured on the same edge as the bit that completes it.
  assign sr_d = {sr_q[WORD_W-2:0], bit_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      word_q <= '0;
    end else begin
      if (clear_i) begin
        sr_q <= '0;
      end else if (shift_i) begin
        sr_q <= sr_d;
      end
      if (load_i) begin
        word_q <= sr_d << pad_i;
      end
    end
  end

  assign word_o = word_q;

`ifdef BINPACK_POPCNT_EN
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (shift_i && bit_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign popcnt_o = cnt_q;
`endif

endmodule

// File: rtl/binpack_b1.sv
// binpack_b1: packs eight per-channel binary activation streams MSB-first into
// shared-address SPRAM words. Define BINPACK_POPCNT_EN to add the popcnt port.
module binpack_b1
  import binpack_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int N_BITS = N_BITS_DEF,
  parameter int ADDR_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [CH-1:0]                  bin_in,
  output logic                           wr_en,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [CH*WORD_W-1:0]           wr_data,
  output logic                           busy,
  output logic                           done,
`ifdef BINPACK_POPCNT_EN
  output logic                           overrun,
  output logic [CH*$clog2(N_BITS+1)-1:0] popcnt
`else
  output logic                           overrun
`endif
);

  localparam int BW = $clog2(WORD_W);
  localparam int TW = $clog2(N_BITS + 1);

  state_e            state_q;
  logic [BW-1:0]     bit_idx_q;
  logic [BW-1:0]     bit_idx_d;
  logic [TW-1:0]     total_q;
  logic [TW-1:0]     total_d;
  logic [ADDR_W-1:0] word_idx_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic              overrun_q;

  logic              accept;
  logic              arm;
  logic              last;
  logic              full;
  logic              load;
  logic [BW-1:0]     pad_sh;

  // start in PACK aborts, so a bit arriving with it is not taken.
  assign accept    = (state_q == PACK) && in_valid && !start;
  assign arm       = start && ((state_q == IDLE) || (state_q == PACK));
  assign bit_idx_d = bit_idx_q + 1'b1;
  assign total_d   = total_q + 1'b1;
  assign last      = accept && (total_d == TW'(N_BITS));
  assign full      = accept && (bit_idx_d == '0) && !last;
  assign load      = full || last;
  // Bits held k = bit_idx_d (0 means a full word); left-align by (WORD_W - k) mod WORD_W.
  assign pad_sh    = last ? BW'(-bit_idx_d) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      total_q    <= '0;
      word_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_en_q <= load;
      done_q  <= 1'b0;
      if (load) begin
        wr_addr_q <= word_idx_q;
      end
      if (in_valid && (state_q != PACK)) begin
        overrun_q <= 1'b1;
      end else if (arm) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= PACK;
            busy_q     <= 1'b1;
            bit_idx_q  <= '0;
            total_q    <= '0;
            word_idx_q <= '0;
          end
        end
        PACK: begin
          if (start) begin
            bit_idx_q  <= '0;
            total_q    <= '0;
            word_idx_q <= '0;
          end else if (accept) begin
            bit_idx_q <= bit_idx_d;
            total_q   <= total_d;
            if (full) begin
              word_idx_q <= word_idx_q + 1'b1;
            end
            if (last) begin
              state_q <= FINAL;
            end
          end
        end
        FINAL: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

  for (genvar gi = 0; gi < CH; gi++) begin : g_lane
`ifdef BINPACK_POPCNT_EN
    binpack_lane #(
      .WORD_W (WORD_W),
      .BW     (BW),
      .CW     (TW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (arm),
      .shift_i  (accept),
      .bit_i    (bin_in[gi]),
      .load_i   (load),
      .pad_i    (pad_sh),
      .word_o   (wr_data[gi*WORD_W +: WORD_W]),
      .popcnt_o (popcnt[gi*TW +: TW])
    );
`else
    binpack_lane #(
      .WORD_W (WORD_W),
      .BW     (BW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear_i (arm),
      .shift_i (accept),
      .bit_i   (bin_in[gi]),
      .load_i  (load),
      .pad_i   (pad_sh),
      .word_o  (wr_data[gi*WORD_W +: WORD_W])
    );
`endif
  end

endmodule
